ctrl_mc: RTL
============

CTRL_MC -- requirements
Module: ctrl_mc

Interface
REQ-001 SHALL have parameter ALU_CTRL_W, default 3 (minimum 3), the width of alu_ctrl.
REQ-002 SHALL have parameter ILL_HALT, default 0; 1 = illegal instruction parks the FSM in HALT, 0 = it returns to IF.
REQ-003 SHALL have ports:
 clk  in  1  single clock, rising edge.
 rst  in  1  asynchronous active-low reset.
 ir_data  in  32  instruction register contents.
 zero  in  1  ALU zero flag.
 mem_ready  in  1  memory completes the current access this cycle.
 mem_req  out  1  memory access active.
 write_pc, iord, write_mem, write_dr, write_ir, memtoreg, regdst, write_c, alu_srcA, write_a, write_b, write_reg  out  1 each  datapath controls.
 pcsource  out  2  00 ALU result, 01 C register, 10 jump target.
 alu_srcB  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
 alu_ctrl  out  ALU_CTRL_W  0 add, 1 sub, 2 and, 3 or, 4 nor, 5 slt.
 illegal  out  1  one-cycle pulse on an illegal instruction.
 state  out  4  current FSM state.
 insn_type  out  4  0 none, 1 R, 2 I-ALU, 3 load, 4 store, 5 branch, 6 jump, 7 illegal.
 insn_code  out  4  ir_data[3:0] for R-type, ir_data[29:26] otherwise.
 insn_stage  out  3  1 IF, 2 ID, 3 EX, 4 MEM, 5 WB, 0 HALT.

Function
REQ-004 SHALL be a Moore FSM encoded as: IF=0, ID=1, EX_ADR=2, MEM_RD=3, WB_LD=4, MEM_WR=5, EX_R=6, WB_R=7, EX_BR=8, EX_J=9, EX_I=10, WB_I=11, ILL=12, HALT=13; codes 14 and 15 SHALL go to IF.
REQ-005 SHALL decode opcodes 0x00 R, 0x23 lw, 0x2B sw, 0x04 beq, 0x05 bne, 0x08 addi, 0x02 j; every other opcode is illegal.
REQ-006 SHALL decode R-type funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x27 nor, 0x2A slt; every other funct is illegal.
REQ-007 IF: mem_req=1, iord=0, alu_srcA=0, alu_srcB=01, add, pcsource=00; write_ir=write_pc=mem_ready; SHALL hold in IF while mem_ready=0.
REQ-008 ID: alu_srcA=0, alu_srcB=11, add, write_a=write_b=write_c=1; next state is EX_ADR for lw/sw, EX_R for R, EX_BR for beq/bne, EX_J for j, EX_I for addi, ILL for illegal.
REQ-009 EX_ADR: alu_srcA=1, alu_srcB=10, add, write_c=1; next state MEM_RD for lw, MEM_WR for sw.
REQ-010 MEM_RD: mem_req=1, iord=1, write_dr=mem_ready; holds until mem_ready, then WB_LD.
REQ-011 WB_LD: regdst=0, memtoreg=1, write_reg=1; next state IF.
REQ-012 MEM_WR: mem_req=1, iord=1, write_mem=1; holds until mem_ready, then IF.
REQ-013 EX_R: alu_srcA=1, alu_srcB=00, alu_ctrl from funct, write_c=1; next state WB_R.
REQ-014 WB_R: regdst=1, memtoreg=0, write_reg=1; next state IF.
REQ-015 EX_BR: alu_srcA=1, alu_srcB=00, sub, pcsource=01; write_pc=zero for beq, ~zero for bne; next state IF.
REQ-016 EX_J: pcsource=10, write_pc=1; next state IF.
REQ-017 EX_I: alu_srcA=1, alu_srcB=10, add, write_c=1; next state WB_I.
REQ-018 WB_I: regdst=0, memtoreg=0, write_reg=1; next state IF.
REQ-019 ILL: illegal=1 with no write enables; next state HALT if ILL_HALT=1, else IF.
REQ-020 HALT: all write enables and mem_req are 0; SHALL leave HALT only on reset.
REQ-021 Any control not listed for a state SHALL be 0.
REQ-022 Cycle counts with mem_ready held at 1: lw 5, sw 4, R 4, addi 4, beq/bne 3, j 3, illegal 3. Each mem_ready=0 cycle in IF, MEM_RD or MEM_WR adds one cycle.
REQ-023 ir_data SHALL be decoded combinationally in every state from ID onward; ir_data SHALL be stable from the write_ir cycle until the next IF.

Reset
REQ-024 While rst=0, the FSM SHALL be in state IF and every write enable, mem_req and illegal SHALL be 0, regardless of mem_ready.
REQ-025 Asserting rst mid-instruction SHALL abort immediately with no further writes; after release the FSM SHALL start at IF.

Verification
REQ-026 lw 0x8C010014, mem_ready=1 -> states 0,1,2,3,4; write_dr in state 3; write_reg with memtoreg=1 in state 4.
REQ-027 add 0x00221820 then nor 0x00853027 -> states 0,1,6,7; alu_ctrl 0 then 4 in EX_R; regdst=1 in WB_R.
REQ-028 sw 0xAC060016 with mem_ready low for 3 cycles in MEM_WR -> write_mem high for 4 cycles, then IF.
REQ-029 beq 0x10220003 with zero=0, and bne 0x14220003 with zero=0 -> write_pc 0 then 1 in EX_BR; pcsource=01.
REQ-030 opcode 0x3F: with ILL_HALT=0 -> illegal pulse, then IF; with ILL_HALT=1 -> HALT persists until rst=0.
REQ-031 rst=0 asserted during MEM_RD -> state 0 at once, write_dr=0, write_reg never asserted.

Source files
------------

// File: rtl/ctrl_mc.sv
// Multi-cycle MIPS-subset control unit: Moore FSM that sequences fetch, decode,
// execute, memory and write-back, and reports the decoded instruction class.
module ctrl_mc #(
   parameter int ALU_CTRL_W = 3,
   parameter bit ILL_HALT   = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           ir_data,
   input  logic                  zero,
   input  logic                  mem_ready,
   output logic                  mem_req,
   output logic                  write_pc,
   output logic                  iord,
   output logic                  write_mem,
   output logic                  write_dr,
   output logic                  write_ir,
   output logic                  memtoreg,
   output logic                  regdst,
   output logic                  write_c,
   output logic                  alu_srcA,
   output logic                  write_a,
   output logic                  write_b,
   output logic                  write_reg,
   output logic [1:0]            pcsource,
   output logic [1:0]            alu_srcB,
   output logic [ALU_CTRL_W-1:0] alu_ctrl,
   output logic                  illegal,
   output logic [3:0]            state,
   output logic [3:0]            insn_type,
   output logic [3:0]            insn_code,
   output logic [2:0]            insn_stage
);

   typedef enum logic [3:0] {
      S_IF     = 4'd0,
      S_ID     = 4'd1,
      S_EX_ADR = 4'd2,
      S_MEM_RD = 4'd3,
      S_WB_LD  = 4'd4,
      S_MEM_WR = 4'd5,
      S_EX_R   = 4'd6,
      S_WB_R   = 4'd7,
      S_EX_BR  = 4'd8,
      S_EX_J   = 4'd9,
      S_EX_I   = 4'd10,
      S_WB_I   = 4'd11,
      S_ILL    = 4'd12,
      S_HALT   = 4'd13
   } state_e;

   typedef enum logic [3:0] {
      T_NONE = 4'd0,
      T_R    = 4'd1,
      T_I    = 4'd2,
      T_LD   = 4'd3,
      T_ST   = 4'd4,
      T_BR   = 4'd5,
      T_J    = 4'd6,
      T_ILL  = 4'd7
   } itype_e;

   state_e       state_q, state_d;
   itype_e       dec_type;
   logic [5:0]   opcode;
   logic [5:0]   funct;
   logic [2:0]   alu_sel;
   logic         unused_ir;

   assign opcode    = ir_data[31:26];
   assign funct     = ir_data[5:0];
   assign unused_ir = ^ir_data[25:6];

   function automatic itype_e decode(input logic [5:0] op, input logic [5:0] fn);
      itype_e t;
      case (op)
         6'h00: begin
            case (fn)
               6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A: t = T_R;
               default:                                  t = T_ILL;
            endcase
         end
         6'h23:        t = T_LD;
         6'h2B:        t = T_ST;
         6'h04, 6'h05: t = T_BR;
         6'h08:        t = T_I;
         6'h02:        t = T_J;
         default:      t = T_ILL;
      endcase
      return t;
   endfunction

   function automatic logic [2:0] alu_of_funct(input logic [5:0] fn);
      logic [2:0] a;
      case (fn)
         6'h22:   a = 3'd1;
         6'h24:   a = 3'd2;
         6'h25:   a = 3'd3;
         6'h27:   a = 3'd4;
         6'h2A:   a = 3'd5;
         default: a = 3'd0;
      endcase
      return a;
   endfunction

   assign dec_type = decode(opcode, funct);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IF;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      mem_req   = 1'b0;
      write_pc  = 1'b0;
      iord      = 1'b0;
      write_mem = 1'b0;
      write_dr  = 1'b0;
      write_ir  = 1'b0;
      memtoreg  = 1'b0;
      regdst    = 1'b0;
      write_c   = 1'b0;
      alu_srcA  = 1'b0;
      write_a   = 1'b0;
      write_b   = 1'b0;
      write_reg = 1'b0;
      pcsource  = 2'b00;
      alu_srcB  = 2'b00;
      alu_sel   = 3'd0;
      illegal   = 1'b0;
      case (state_q)
         S_IF: begin
            mem_req  = 1'b1;
            alu_srcB = 2'b01;
            write_ir = mem_ready;
            write_pc = mem_ready;
            if (mem_ready) state_d = S_ID;
         end
         S_ID: begin
            alu_srcB = 2'b11;
            write_a  = 1'b1;
            write_b  = 1'b1;
            write_c  = 1'b1;
            case (dec_type)
               T_LD, T_ST: state_d = S_EX_ADR;
               T_R:        state_d = S_EX_R;
               T_BR:       state_d = S_EX_BR;
               T_J:        state_d = S_EX_J;
               T_I:        state_d = S_EX_I;
               default:    state_d = S_ILL;
            endcase
         end
         S_EX_ADR: begin
            alu_srcA = 1'b1;
            alu_srcB = 2'b10;
            write_c  = 1'b1;
            state_d  = (dec_type == T_ST) ? S_MEM_WR : S_MEM_RD;
         end
         S_MEM_RD: begin
            mem_req  = 1'b1;
            iord     = 1'b1;
            write_dr = mem_ready;
            if (mem_ready) state_d = S_WB_LD;
         end
         S_WB_LD: begin
            memtoreg  = 1'b1;
            write_reg = 1'b1;
            state_d   = S_IF;
         end
         S_MEM_WR: begin
            mem_req   = 1'b1;
            iord      = 1'b1;
            write_mem = 1'b1;
            if (mem_ready) state_d = S_IF;
         end
         S_EX_R: begin
            alu_srcA = 1'b1;
            alu_sel  = alu_of_funct(funct);
            write_c  = 1'b1;
            state_d  = S_WB_R;
         end
         S_WB_R: begin
            regdst    = 1'b1;
            write_reg = 1'b1;
            state_d   = S_IF;
         end
         S_EX_BR: begin
            alu_srcA = 1'b1;
            alu_sel  = 3'd1;
            pcsource = 2'b01;
            // opcode bit 0 distinguishes bne (0x05) from beq (0x04)
            write_pc = opcode[0] ? ~zero : zero;
            state_d  = S_IF;
         end
         S_EX_J: begin
            pcsource = 2'b10;
            write_pc = 1'b1;
            state_d  = S_IF;
         end
         S_EX_I: begin
            alu_srcA = 1'b1;
            alu_srcB = 2'b10;
            write_c  = 1'b1;
            state_d  = S_WB_I;
         end
         S_WB_I: begin
            write_reg = 1'b1;
            state_d   = S_IF;
         end
         S_ILL: begin
            illegal = 1'b1;
            state_d = ILL_HALT ? S_HALT : S_IF;
         end
         S_HALT: state_d = S_HALT;
         default: state_d = S_IF;
      endcase
      // Reset must silence every side effect, even IF's mem_ready-driven writes
      if (!rst) begin
         mem_req   = 1'b0;
         write_pc  = 1'b0;
         write_mem = 1'b0;
         write_dr  = 1'b0;
         write_ir  = 1'b0;
         write_c   = 1'b0;
         write_a   = 1'b0;
         write_b   = 1'b0;
         write_reg = 1'b0;
         illegal   = 1'b0;
      end
   end

   assign alu_ctrl  = ALU_CTRL_W'(alu_sel);
   assign state     = state_q;
   assign insn_type = (state_q == S_IF || state_q == S_HALT) ? T_NONE : dec_type;
   assign insn_code = (opcode == 6'h00) ? ir_data[3:0] : ir_data[29:26];

   always_comb begin
      case (state_q)
         S_IF:                                          insn_stage = 3'd1;
         S_ID:                                          insn_stage = 3'd2;
         S_EX_ADR, S_EX_R, S_EX_BR, S_EX_J, S_EX_I, S_ILL: insn_stage = 3'd3;
         S_MEM_RD, S_MEM_WR:                            insn_stage = 3'd4;
         S_WB_LD, S_WB_R, S_WB_I:                       insn_stage = 3'd5;
         default:                                       insn_stage = 3'd0;
      endcase
   end

endmodule
